// File: rtl/mcpu_dram_arbiter.sv
// Single-port data RAM arbiter: the MCPU core always wins with zero latency,
// a single queued host/debug request executes in the next core-idle cycle.
module mcpu_dram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] core_addr,
    input  logic                  core_re,
    input  logic                  core_we,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rdata_oe,
    output logic                  core_addr_err,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_busy,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_starved,
    output logic [15:0]           conflict_cnt,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t state_q, state_d;

    logic                  pend_we_q, pend_we_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_wdata_q, pend_wdata_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic [15:0]           conflict_cnt_q, conflict_cnt_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic                  host_starved_q, host_starved_d;
    logic                  core_addr_err_q, core_addr_err_d;

    logic core_active;
    logic addr_ok;
    logic host_exec;
    logic host_blocked;

    assign core_active = core_re | core_we;
    assign addr_ok     = (core_addr[DATA_WIDTH-1:ADDR_WIDTH] == '0);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (host_req) state_d = S_WAIT;
            S_WAIT: if (!core_active) state_d = S_ACK;
            S_ACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        host_busy    = 1'b0;
        host_ack     = 1'b0;
        host_exec    = 1'b0;
        host_blocked = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                host_busy    = 1'b1;
                host_exec    = !core_active;
                host_blocked = core_active;
            end
            S_ACK: begin
                host_busy = 1'b1;
                host_ack  = 1'b1;
            end
            default: ;
        endcase
    end

    // RAM port mux: core first, then the pending host access, else quiet
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (core_active) begin
            ram_addr  = core_addr[ADDR_WIDTH-1:0];
            ram_we    = core_we & addr_ok;
            ram_wdata = core_wdata;
        end else if (host_exec) begin
            ram_addr  = pend_addr_q;
            ram_we    = pend_we_q;
            ram_wdata = pend_we_q ? pend_wdata_q : '0;
        end
    end

    assign core_rdata    = (core_re & addr_ok) ? ram_rdata : '0;
    assign core_rdata_oe = core_re;

    always_comb begin
        pend_we_d       = pend_we_q;
        pend_addr_d     = pend_addr_q;
        pend_wdata_d    = pend_wdata_q;
        wait_cnt_d      = wait_cnt_q;
        conflict_cnt_d  = conflict_cnt_q;
        host_rdata_d    = host_rdata_q;
        core_addr_err_d = core_active & !addr_ok;

        if (state_q == S_IDLE && host_req) begin
            pend_we_d    = host_we;
            pend_addr_d  = host_addr;
            pend_wdata_d = host_wdata;
        end

        if (host_blocked) begin
            wait_cnt_d     = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end

        if (host_exec) begin
            wait_cnt_d = 8'd0;
            if (!pend_we_q) begin
                host_rdata_d = ram_rdata;
            end
        end

        // registered, but from the next count so it rises with the count
        host_starved_d = (wait_cnt_d >= MAX_WAIT_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_we_q       <= 1'b0;
            pend_addr_q     <= '0;
            pend_wdata_q    <= '0;
            wait_cnt_q      <= 8'd0;
            conflict_cnt_q  <= 16'd0;
            host_rdata_q    <= '0;
            host_starved_q  <= 1'b0;
            core_addr_err_q <= 1'b0;
        end else begin
            pend_we_q       <= pend_we_d;
            pend_addr_q     <= pend_addr_d;
            pend_wdata_q    <= pend_wdata_d;
            wait_cnt_q      <= wait_cnt_d;
            conflict_cnt_q  <= conflict_cnt_d;
            host_rdata_q    <= host_rdata_d;
            host_starved_q  <= host_starved_d;
            core_addr_err_q <= core_addr_err_d;
        end
    end

    assign host_rdata    = host_rdata_q;
    assign host_starved  = host_starved_q;
    assign conflict_cnt  = conflict_cnt_q;
    assign core_addr_err = core_addr_err_q;

endmodule

// File: tb/tb_mcpu_dram_arbiter.sv
// Bench for mcpu_dram_arbiter: directed scenarios plus a random run
// checked against a transaction-level model of core and host behaviour.
module tb_mcpu_dram_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] core_addr, core_wdata, core_rdata;
    logic          core_re, core_we, core_rdata_oe, core_addr_err;
    logic          host_req, host_we, host_busy, host_ack, host_starved;
    logic [AW-1:0] host_addr, ram_addr;
    logic [DW-1:0] host_wdata, host_rdata, ram_wdata, ram_rdata;
    logic [15:0]   conflict_cnt;
    logic          ram_we;

    logic [DW-1:0] mem [256] = '{default: 32'hC0DE_0000};
    logic [DW-1:0] ref_mem [256];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

    mcpu_dram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .core_addr(core_addr), .core_re(core_re), .core_we(core_we),
        .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_rdata_oe(core_rdata_oe), .core_addr_err(core_addr_err),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_busy(host_busy), .host_ack(host_ack),
        .host_rdata(host_rdata), .host_starved(host_starved),
        .conflict_cnt(conflict_cnt), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_re = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 0;
        #2;
        reset = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        @(negedge clk);
        vectors++; if (host_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", host_busy); end
        vectors++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0h want 0", host_ack); end
        vectors++; if (host_starved !== 1'b0) begin errors++; $display("FAIL reset_starved got %0h want 0", host_starved); end
        vectors++; if (core_addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %0h want 0", core_addr_err); end
        vectors++; if (host_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", host_rdata); end
        vectors++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_conflict got %0d want 0", conflict_cnt); end
        vectors++; if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            errors++; $display("FAIL reset_ram_idle got we=%0h addr=%h wd=%h want 0", ram_we, ram_addr, ram_wdata);
        end
        #2;
        reset = 1;
        tick();
    endtask

    task automatic test_core_rw();
        core_we = 1; core_addr = 32'h05; core_wdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++; if (ram_we !== 1'b1 || ram_addr !== 8'h05 || ram_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL core_write got we=%0h addr=%h wd=%h want 1/05/deadbeef", ram_we, ram_addr, ram_wdata);
        end
        tick();
        ref_mem[5] = 32'hDEADBEEF;
        core_we = 0; core_re = 1;
        @(negedge clk);
        vectors++; if (core_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_read got %h want deadbeef", core_rdata); end
        vectors++; if (core_rdata_oe !== 1'b1) begin errors++; $display("FAIL core_oe got %0h want 1", core_rdata_oe); end
        vectors++; if (host_busy !== 1'b0) begin errors++; $display("FAIL core_busy got %0h want 0", host_busy); end
        tick();
        idle_inputs();
        @(negedge clk);
        vectors++; if (core_rdata !== '0 || core_rdata_oe !== 1'b0) begin
            errors++; $display("FAIL core_noread got %h/%0h want 0/0", core_rdata, core_rdata_oe);
        end
        tick();
    endtask

    task automatic test_host_write_read();
        host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 32'h1234;
        tick();
        idle_inputs();
        @(negedge clk);
        vectors++; if (ram_we !== 1'b1 || ram_addr !== 8'h10 || ram_wdata !== 32'h1234) begin
            errors++; $display("FAIL hwr_exec got we=%0h addr=%h wd=%h want 1/10/1234", ram_we, ram_addr, ram_wdata);
        end
        vectors++; if (host_busy !== 1'b1 || host_ack !== 1'b0) begin
            errors++; $display("FAIL hwr_n1 got busy=%0h ack=%0h want 1/0", host_busy, host_ack);
        end
        tick();
        ref_mem[8'h10] = 32'h1234;
        @(negedge clk);
        vectors++; if (host_ack !== 1'b1 || host_busy !== 1'b1) begin
            errors++; $display("FAIL hwr_ack got ack=%0h busy=%0h want 1/1", host_ack, host_busy);
        end
        tick();
        host_req = 1; host_we = 0; host_addr = 8'h10;
        @(negedge clk);
        vectors++; if (host_ack !== 1'b0 || host_busy !== 1'b0) begin
            errors++; $display("FAIL hrd_idle got ack=%0h busy=%0h want 0/0", host_ack, host_busy);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        vectors++; if (ram_we !== 1'b0 || ram_addr !== 8'h10) begin
            errors++; $display("FAIL hrd_exec got we=%0h addr=%h want 0/10", ram_we, ram_addr);
        end
        tick();
        @(negedge clk);
        vectors++; if (host_ack !== 1'b1 || host_rdata !== 32'h1234) begin
            errors++; $display("FAIL hrd_ack got ack=%0h rdata=%h want 1/1234", host_ack, host_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic exp_st;
        pulse_reset();
        host_req = 1; host_we = 0; host_addr = 8'h20;
        tick();
        idle_inputs();
        for (int k = 1; k <= 20; k++) begin
            core_re = 1; core_addr = 32'h40;
            exp_st = (k >= 16);
            @(negedge clk);
            vectors++; if (host_ack !== 1'b0 || host_busy !== 1'b1) begin
                errors++; $display("FAIL starve_blk%0d got ack=%0h busy=%0h want 0/1", k, host_ack, host_busy);
            end
            vectors++; if (host_starved !== exp_st) begin
                errors++; $display("FAIL starve_flag%0d got %0h want %0h", k, host_starved, exp_st);
            end
            vectors++; if (conflict_cnt !== 16'(k - 1)) begin
                errors++; $display("FAIL starve_cnt%0d got %0d want %0d", k, conflict_cnt, k - 1);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        vectors++; if (ram_addr !== 8'h20 || ram_we !== 1'b0 || host_ack !== 1'b0) begin
            errors++; $display("FAIL starve_exec got addr=%h we=%0h ack=%0h want 20/0/0", ram_addr, ram_we, host_ack);
        end
        vectors++; if (conflict_cnt !== 16'd20 || host_starved !== 1'b1) begin
            errors++; $display("FAIL starve_exec_st got cnt=%0d st=%0h want 20/1", conflict_cnt, host_starved);
        end
        tick();
        @(negedge clk);
        vectors++; if (host_ack !== 1'b1 || host_rdata !== ref_mem[8'h20]) begin
            errors++; $display("FAIL starve_ack got ack=%0h rdata=%h want 1/%h", host_ack, host_rdata, ref_mem[8'h20]);
        end
        vectors++; if (host_starved !== 1'b0 || conflict_cnt !== 16'd20) begin
            errors++; $display("FAIL starve_clear got st=%0h cnt=%0d want 0/20", host_starved, conflict_cnt);
        end
        tick();
    endtask

    task automatic test_hazard();
        host_req = 1; host_we = 0; host_addr = 8'h30;
        tick();
        idle_inputs();
        core_we = 1; core_addr = 32'h30; core_wdata = 32'hAA;
        tick();
        ref_mem[8'h30] = 32'hAA;
        idle_inputs();
        @(negedge clk);
        vectors++; if (ram_addr !== 8'h30 || host_busy !== 1'b1) begin
            errors++; $display("FAIL hazard_exec got addr=%h busy=%0h want 30/1", ram_addr, host_busy);
        end
        tick();
        @(negedge clk);
        vectors++; if (host_ack !== 1'b1 || host_rdata !== 32'hAA) begin
            errors++; $display("FAIL hazard_ack got ack=%0h rdata=%h want 1/aa", host_ack, host_rdata);
        end
        tick();
    endtask

    task automatic test_addr_err();
        core_we = 1; core_addr = 32'h100; core_wdata = 32'h5555;
        @(negedge clk);
        vectors++; if (ram_we !== 1'b0 || core_addr_err !== 1'b0) begin
            errors++; $display("FAIL aerr_wr got we=%0h err=%0h want 0/0", ram_we, core_addr_err);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        vectors++; if (core_addr_err !== 1'b1) begin errors++; $display("FAIL aerr_pulse got %0h want 1", core_addr_err); end
        tick();
        @(negedge clk);
        vectors++; if (core_addr_err !== 1'b0) begin errors++; $display("FAIL aerr_single got %0h want 0", core_addr_err); end
        tick();
        core_re = 1; core_addr = 32'h100;
        @(negedge clk);
        vectors++; if (core_rdata !== '0 || core_rdata_oe !== 1'b1) begin
            errors++; $display("FAIL aerr_rd got %h/%0h want 0/1", core_rdata, core_rdata_oe);
        end
        tick();
        core_addr = 32'h0;
        @(negedge clk);
        vectors++; if (core_rdata !== ref_mem[0]) begin
            errors++; $display("FAIL aerr_ram got %h want %h", core_rdata, ref_mem[0]);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_in_wait();
        host_req = 1; host_we = 0; host_addr = 8'h50;
        tick();
        idle_inputs();
        core_re = 1; core_addr = 32'h7;
        #2;
        reset = 0;
        @(negedge clk);
        vectors++; if (host_busy !== 1'b0 || host_ack !== 1'b0 || host_starved !== 1'b0) begin
            errors++; $display("FAIL rstw_now got busy=%0h ack=%0h st=%0h want 0/0/0", host_busy, host_ack, host_starved);
        end
        #2;
        reset = 1;
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++; if (host_ack !== 1'b0 || host_busy !== 1'b0) begin
                errors++; $display("FAIL rstw_quiet%0d got ack=%0h busy=%0h want 0/0", k, host_ack, host_busy);
            end
            tick();
        end
        host_req = 1; host_we = 1; host_addr = 8'h44; host_wdata = 32'h77;
        tick();
        idle_inputs();
        tick();
        ref_mem[8'h44] = 32'h77;
        @(negedge clk);
        vectors++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rstw_new got ack=%0h want 1", host_ack); end
        tick();
    endtask

    task automatic test_random();
        bit            pend, ackn, err_prev, active, ok, chk_wd;
        logic          pw, e_we, e_st;
        logic [AW-1:0] pa, e_addr;
        logic [DW-1:0] pd, rd_exp, a, d, e_wd, e_cr;
        logic [15:0]   confl;
        int            waited, sel;
        pulse_reset();
        pend = 0; ackn = 0; err_prev = 0; waited = 0; confl = 0;
        rd_exp = '0; pw = 0; pa = '0; pd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            sel = ((cyc % 100) < 20) ? $urandom_range(2, 3) : $urandom_range(0, 3);
            a = DW'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(8, 31));
            d = $urandom;
            core_re = (sel == 2); core_we = (sel == 3);
            core_addr = a; core_wdata = d;
            host_req = ($urandom_range(0, 2) == 0); host_we = $urandom_range(0, 1);
            host_addr = AW'($urandom_range(0, 255)); host_wdata = $urandom;
            active = core_re || core_we;
            ok = (a >> AW) == 0;
            e_cr = (core_re && ok) ? ref_mem[a[AW-1:0]] : '0;
            e_st = pend && (waited >= MW);
            chk_wd = 1;
            if (active) begin
                e_addr = a[AW-1:0]; e_we = core_we && ok; e_wd = d;
            end else if (pend) begin
                e_addr = pa; e_we = pw; e_wd = pd; chk_wd = pw;
            end else begin
                e_addr = '0; e_we = 0; e_wd = '0;
            end
            @(negedge clk);
            vectors++; if (core_rdata !== e_cr || core_rdata_oe !== core_re) begin
                errors++; $display("FAIL rnd%0d core_rd got %h/%0h want %h/%0h", cyc, core_rdata, core_rdata_oe, e_cr, core_re);
            end
            vectors++; if (core_addr_err !== err_prev) begin
                errors++; $display("FAIL rnd%0d addr_err got %0h want %0h", cyc, core_addr_err, err_prev);
            end
            vectors++; if (host_busy !== (pend || ackn) || host_ack !== ackn) begin
                errors++; $display("FAIL rnd%0d host got busy=%0h ack=%0h want %0h/%0h", cyc, host_busy, host_ack, pend || ackn, ackn);
            end
            vectors++; if (host_starved !== e_st) begin
                errors++; $display("FAIL rnd%0d starved got %0h want %0h", cyc, host_starved, e_st);
            end
            vectors++; if (conflict_cnt !== confl || host_rdata !== rd_exp) begin
                errors++; $display("FAIL rnd%0d cnt/rdata got %0d/%h want %0d/%h", cyc, conflict_cnt, host_rdata, confl, rd_exp);
            end
            vectors++; if (ram_we !== e_we || ram_addr !== e_addr || (chk_wd && ram_wdata !== e_wd)) begin
                errors++; $display("FAIL rnd%0d ram got we=%0h a=%h wd=%h want %0h/%h/%h", cyc, ram_we, ram_addr, ram_wdata, e_we, e_addr, e_wd);
            end
            err_prev = active && !ok;
            if (core_we && ok) ref_mem[a[AW-1:0]] = d;
            if (ackn) begin
                ackn = 0;
            end else if (pend) begin
                if (active) begin
                    waited = (waited < 255) ? waited + 1 : 255;
                    confl = confl + 16'd1;
                end else begin
                    if (pw) ref_mem[pa] = pd;
                    else rd_exp = ref_mem[pa];
                    pend = 0; waited = 0; ackn = 1;
                end
            end else if (host_req) begin
                pend = 1; pw = host_we; pa = host_addr; pd = host_wdata;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE_0000;
        test_reset();
        test_core_rw();
        test_host_write_read();
        test_starvation();
        test_hazard();
        test_addr_err();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
